// File: rtl/bwt_stream_ctrl.sv
// Flow-controlled BWT front/back end around an external suffix-array sorter.
// Define BWT_PRIMARY_IDX_EN to append the primary index as one extra output beat.
module bwt_stream_ctrl #(
    parameter int  CHAR_W  = 8,
    parameter int  MAX_LEN = 32,
    localparam int IDX_W   = $clog2(MAX_LEN)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHAR_W-1:0]         in_data,
    input  logic                      in_last,
    output logic                      sort_start,
    output logic [IDX_W:0]            sort_len,
    output logic [MAX_LEN*CHAR_W-1:0] sort_str,
    input  logic                      sort_done,
    input  logic [MAX_LEN*IDX_W-1:0]  sort_sa,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHAR_W-1:0]         out_data,
    output logic                      out_last,
    output logic                      busy
);
    // state | meaning
    // FILL  | accept input characters into the character buffer
    // SORT  | frame handed to sorter, waiting for sort_done
    // DRAIN | emit one BWT character per output handshake
    // IDX   | emit the primary index beat (BWT_PRIMARY_IDX_EN only)
`ifdef BWT_PRIMARY_IDX_EN
    typedef enum logic [1:0] {S_FILL, S_SORT, S_DRAIN, S_IDX} state_t;
`else
    typedef enum logic [1:0] {S_FILL, S_SORT, S_DRAIN} state_t;
`endif
    state_t state_q, state_d;

    logic [CHAR_W-1:0] char_q [MAX_LEN];
    logic [IDX_W-1:0]  sa_q   [MAX_LEN];
    logic [IDX_W-1:0]  wr_ptr_q;
    logic [IDX_W-1:0]  src_pos;
    logic [IDX_W:0]    len_q, rd_ptr_q, sa_pos;
    logic              sort_start_q, out_valid_q, out_last_q;
    logic [CHAR_W-1:0] out_data_q;
    logic              in_fire, out_fire, fill_end, load_beat, last_bwt_fire;
`ifdef BWT_PRIMARY_IDX_EN
    logic [IDX_W-1:0]  prim_q;
`endif

    assign in_ready   = (state_q == S_FILL);
    assign busy       = (state_q != S_FILL);
    assign sort_start = sort_start_q;
    assign sort_len   = len_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign fill_end = in_fire && (in_last || wr_ptr_q == IDX_W'(MAX_LEN - 1));
    // rd_ptr_q counts beats already loaded, so rd_ptr_q == len_q means beat L-1 is on the bus
    assign last_bwt_fire = (state_q == S_DRAIN) && out_fire && (rd_ptr_q == len_q);
    assign load_beat     = (state_q == S_DRAIN) && (rd_ptr_q < len_q) && (!out_valid_q || out_ready);

    // Out-of-range sorter entries are folded back with mod L
    always_comb begin
        sa_pos  = '0;
        src_pos = '0;
        if (len_q != '0) begin
            sa_pos  = {1'b0, sa_q[rd_ptr_q[IDX_W-1:0]]} % len_q;
            src_pos = (sa_pos == '0) ? IDX_W'(len_q - 1'b1) : IDX_W'(sa_pos - 1'b1);
        end
    end

    always_comb begin
        sort_str = '0;
        for (int k = 0; k < MAX_LEN; k++)
            sort_str[k*CHAR_W +: CHAR_W] = char_q[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FILL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FILL:  if (fill_end) state_d = S_SORT;
            S_SORT:  if (sort_done) state_d = S_DRAIN;
`ifdef BWT_PRIMARY_IDX_EN
            S_DRAIN: if (last_bwt_fire) state_d = S_IDX;
            S_IDX:   if (out_fire) state_d = S_FILL;
`else
            S_DRAIN: if (last_bwt_fire) state_d = S_FILL;
`endif
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                char_q[k] <= '0;
                sa_q[k]   <= '0;
            end
            wr_ptr_q     <= '0;
            len_q        <= '0;
            rd_ptr_q     <= '0;
            sort_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
`ifdef BWT_PRIMARY_IDX_EN
            prim_q       <= '0;
`endif
        end else begin
            sort_start_q <= fill_end;
            if (in_fire) begin
                char_q[wr_ptr_q] <= in_data;
                if (!fill_end) wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (fill_end) len_q <= {1'b0, wr_ptr_q} + 1'b1;

            if (state_q == S_SORT && sort_done) begin
                for (int k = 0; k < MAX_LEN; k++)
                    sa_q[k] <= sort_sa[k*IDX_W +: IDX_W];
                rd_ptr_q <= '0;
`ifdef BWT_PRIMARY_IDX_EN
                prim_q   <= '0;
`endif
            end

            if (load_beat) begin
                out_valid_q <= 1'b1;
                out_data_q  <= char_q[src_pos];
`ifdef BWT_PRIMARY_IDX_EN
                out_last_q  <= 1'b0;
                if (sa_pos == '0) prim_q <= rd_ptr_q[IDX_W-1:0];
`else
                out_last_q  <= (rd_ptr_q == len_q - 1'b1);
`endif
                rd_ptr_q    <= rd_ptr_q + 1'b1;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end

            if (last_bwt_fire) begin
                for (int k = 0; k < MAX_LEN; k++)
                    char_q[k] <= '0;
                wr_ptr_q <= '0;
`ifdef BWT_PRIMARY_IDX_EN
                out_valid_q <= 1'b1;
                out_data_q  <= CHAR_W'(prim_q);
                out_last_q  <= 1'b1;
`endif
            end
        end
    end
endmodule
